// File: rtl/downcount_pkg.sv
// Shared types and helpers for the loadable down-counting timer.
package downcount_pkg;

  // Controller states: waiting, counting, terminal count reached (one-shot).
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } dc_state_t;

  // Counter width for a modulus of n; a modulus of 1 still needs one bit.
  function automatic int dc_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/downcount_timer_if.sv
// Control/status bundle of the down-counting timer.
interface downcount_timer_if #(
  parameter int W = 4
) ();
  logic         i_load;
  logic [W-1:0] i_load_val;
  logic         i_start;
  logic         i_enable;
  logic         i_abort;
  logic         i_auto_reload;
  logic [W-1:0] o_val;
  logic         o_last;
  logic         o_done;
  logic         o_busy;

  // Controller side drives commands and observes the timer.
  modport master (
    output i_load, i_load_val, i_start, i_enable, i_abort, i_auto_reload,
    input  o_val, o_last, o_done, o_busy
  );

  // Timer side.
  modport slave (
    input  i_load, i_load_val, i_start, i_enable, i_abort, i_auto_reload,
    output o_val, o_last, o_done, o_busy
  );
endinterface

// File: rtl/downcount_timer.sv
// Loadable modulo-N down-counter with terminal-count pulse, one-shot or
// auto-reload operation. Priority each cycle: abort > load > start > enable.
module downcount_timer
  import downcount_pkg::*;
#(
  parameter  int N = 16,
  localparam int W = dc_width(N)
) (
  input  logic         clk,
  input  logic         areset_n,
  downcount_timer_if.slave bus
);

  localparam logic [W-1:0] MAX_VAL = W'(N - 1);
  localparam logic [W-1:0] ZERO    = W'(0);

  dc_state_t    state;
  dc_state_t    state_nxt;
  logic [W-1:0] count;
  logic [W-1:0] count_nxt;
  logic [W-1:0] reload;
  logic [W-1:0] reload_nxt;
  logic         done;
  logic         done_nxt;
  logic [W-1:0] load_sat;
  logic [W-1:0] load_eff;

  // Clamp a requested reload value into the 0..N-1 range.
  function automatic logic [W-1:0] sat(input logic [W-1:0] v);
    logic [W-1:0] r;
    if (v > MAX_VAL) begin
      r = MAX_VAL;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // State, count, reload register and done pulse; reset discards all progress.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state  <= S_IDLE;
      count  <= MAX_VAL;
      reload <= MAX_VAL;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      reload <= reload_nxt;
      done   <= done_nxt;
    end
  end

  // Next-state logic; a same-cycle load is seen by abort, start and wrap.
  always_comb begin
    load_sat   = sat(bus.i_load_val);
    load_eff   = bus.i_load ? load_sat : reload;
    state_nxt  = state;
    count_nxt  = count;
    reload_nxt = bus.i_load ? load_sat : reload;
    done_nxt   = 1'b0;
    if (bus.i_abort) begin
      state_nxt = S_IDLE;
      count_nxt = load_eff;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.i_start) begin
            state_nxt = S_RUN;
            count_nxt = load_eff;
          end else if (bus.i_load) begin
            count_nxt = load_sat;
          end else begin
            count_nxt = count;
          end
        end
        S_RUN: begin
          if (!bus.i_enable) begin
            count_nxt = count;
          end else if (count != ZERO) begin
            count_nxt = count - W'(1);
          end else begin
            // Terminal count: pulse done, then wrap or stop at zero.
            done_nxt = 1'b1;
            if (bus.i_auto_reload) begin
              count_nxt = load_eff;
            end else begin
              state_nxt = S_DONE;
              count_nxt = ZERO;
            end
          end
        end
        default: begin
          state_nxt = S_IDLE;
          count_nxt = reload;
        end
      endcase
    end
  end

  // Output decode; o_last follows the count combinationally.
  always_comb begin
    bus.o_val  = count;
    bus.o_done = done;
    bus.o_busy = (state == S_RUN);
    bus.o_last = (count == ZERO);
  end

endmodule
